square_wave_gen: RTL and testbench

Programmable square-wave generator. High time is i_m × 100 ns and low time is i_n × 100 ns, with a 100 MHz system clock, so one time unit is 10 clocks. It is a standalone peripheral driving one output pin or a downstream logic input. It is a two-state FSM plus one down-counter, and the output is registered.

---
 rtl/square_wave_pkg.sv | 20 ++
 rtl/square_wave_gen.sv | 86 ++++++++
 tb/tb_square_wave_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/square_wave_pkg.sv
// Shared types and default constants for the programmable square-wave generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: state_t FSM encoding, default UNIT_CYCLES / MN_W, and the counter
// width CNT_W derived from them.
package square_wave_pkg;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } state_t;

    // Clocks per time unit: 100 ns at 100 MHz.
    localparam int UNIT_CYCLES = 10;
    // Width of the high/low length inputs.
    localparam int MN_W = 4;
    // Wide enough to hold the longest phase minus one.
    localparam int CNT_W = $clog2(UNIT_CYCLES * ((2 ** MN_W) - 1));

endpackage

// File: rtl/square_wave_gen.sv
// Programmable square wave: high for i_m units, low for i_n units (1 unit = UNIT_CYCLES clocks).
// Latency: o_q changes on the first rising edge after a phase end; it is high on the first edge after reset when i_m != 0.
// Backpressure: none; free-running output. i_m and i_n are sampled only at phase ends.
//
// Ports:
//   i_clk  - system clock, rising-edge active
//   i_rst  - asynchronous active-low reset
//   i_m    - high-phase length in units
//   i_n    - low-phase length in units
//   o_q    - square-wave output, taken straight from the state register
module square_wave_gen
    import square_wave_pkg::state_t;
    import square_wave_pkg::LOW;
    import square_wave_pkg::HIGH;
#(
    parameter int UNIT_CYCLES = square_wave_pkg::UNIT_CYCLES,
    parameter int MN_W        = square_wave_pkg::MN_W
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [MN_W-1:0] i_m,
    input  logic [MN_W-1:0] i_n,
    output logic            o_q
);

    localparam int CNT_W = $clog2(UNIT_CYCLES * ((2 ** MN_W) - 1));

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    // Counter reload value for a phase of 'len' units. A zero length keeps the
    // counter at 0 so the phase-end check repeats on every clock.
    function automatic logic [CNT_W-1:0] phase_len(input logic [MN_W-1:0] len);
        logic [CNT_W-1:0] cycles;
        cycles = CNT_W'(len) * CNT_W'(UNIT_CYCLES);
        return (len == '0) ? '0 : cycles - CNT_W'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt - CNT_W'(1);
        if (cnt == '0) begin
            case (state)
                LOW: begin
                    if (i_m != '0) begin
                        state_nxt = HIGH;
                        cnt_nxt   = phase_len(i_m);
                    end else begin
                        // No high phase requested: extend the low phase.
                        cnt_nxt   = phase_len(i_n);
                    end
                end
                HIGH: begin
                    if (i_n != '0) begin
                        state_nxt = LOW;
                        cnt_nxt   = phase_len(i_n);
                    end else begin
                        // No low phase requested: extend the high phase.
                        cnt_nxt   = phase_len(i_m);
                    end
                end
                default: begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Reset leaves the counter expired so the first edge after release
    // immediately evaluates a transition.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign o_q = (state == HIGH);

endmodule

// File: tb/tb_square_wave_gen.sv
module tb_square_wave_gen;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [3:0] i_m   = 4'd1;
    logic [3:0] i_n   = 4'd1;
    logic       o_q;

    square_wave_gen #(
        .UNIT_CYCLES(10),
        .MN_W       (4)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_m  (i_m),
        .i_n  (i_n),
        .o_q  (o_q)
    );

    always #5 i_clk = ~i_clk;

    // Scoreboard: one expected o_q level per clock edge, popped at each negedge.
    logic exp_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    bit   mon_en = 1'b0;

    // Reference model state: current output level and cycles left in the
    // segment that is currently being played out.
    bit   level   = 1'b0;
    int   rem     = 0;
    int   seg_len = 0;

    task automatic check(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: o_q=%b expected %b at t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty: o_q=%b with no expected value at t=%0t", o_q, $time);
            end else begin
                check("wave", o_q, exp_q.pop_front());
            end
        end
    end

    // At a phase boundary, decide the next segment from the inputs as they are
    // right before the boundary edge and queue its full expected waveform.
    task automatic plan_segment();
        int units;
        bit nxt;
        if (level == 1'b0) begin
            if (i_m != 0) begin nxt = 1'b1; units = int'(i_m); end
            else          begin nxt = 1'b0; units = int'(i_n); end
        end else begin
            if (i_n != 0) begin nxt = 1'b0; units = int'(i_n); end
            else          begin nxt = 1'b1; units = int'(i_m); end
        end
        level   = nxt;
        seg_len = (units == 0) ? 1 : units * 10;
        rem     = seg_len;
        repeat (seg_len) exp_q.push_back(nxt);
    endtask

    task automatic step();
        if (rem == 0) plan_segment();
        @(posedge i_clk);
        #2;
        rem--;
    endtask

    // Run n_cyc clocks; just before cycle 'at' the inputs change to m/n.
    task automatic run(input int n_cyc, input int at, input logic [3:0] m, input logic [3:0] n);
        for (int c = 0; c < n_cyc; c++) begin
            if (c == at) begin
                i_m = m;
                i_n = n;
            end
            step();
        end
    endtask

    task automatic reset_mid_high();
        int guard = 0;
        while (!(level == 1'b1 && seg_len > 1 && rem == seg_len / 2) && guard < 2000) begin
            step();
            guard++;
        end
        if (guard >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL reach_mid_high: no HIGH phase reached within %0d cycles", guard);
        end
        // Abandon the rest of the segment; reset forces 0 from here on.
        exp_q.delete();
        exp_q.push_back(1'b0);
        #1 i_rst = 1'b0;
        #1 check("async_reset_immediate", o_q, 1'b0);
        @(posedge i_clk);
        #2 exp_q.push_back(1'b0);
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        exp_q.push_back(1'b0);
        level = 1'b0;
        rem   = 0;
    endtask

    initial begin
        // Reset held: output must sit at 0.
        repeat (3) begin
            @(posedge i_clk);
            #1 check("reset_hold", o_q, 1'b0);
        end
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        exp_q.push_back(1'b0);
        mon_en = 1'b1;

        run(40, -1, 4'd1, 4'd1);
        run(205, 7, 4'd5, 4'd5);
        run(600, 3, 4'd15, 4'd15);
        run(400, 50, 4'd15, 4'd2);
        run(60, 10, 4'd0, 4'd0);
        run(60, 5, 4'd0, 4'd3);
        run(60, 5, 4'd4, 4'd0);
        run(30, 0, 4'd2, 4'd2);
        run(60, 5, 4'd0, 4'd0);

        for (int k = 0; k < 25; k++) begin
            logic [3:0] rm;
            logic [3:0] rn;
            rm = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            rn = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            run(int'($urandom_range(20, 250)), int'($urandom_range(0, 19)), rm, rn);
        end

        run(5, 0, 4'd3, 4'd2);
        reset_mid_high();
        run(100, -1, 4'd3, 4'd2);

        @(negedge i_clk);
        #1 mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
